pwm_mc: RTL and testbench
=========================

PWM_MC -- requirements
Module: pwm_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of PWM channels (1..16).
REQ-002 SHALL have parameter B_WIDTH, default 8, period counter and duty width in bits (2..16); MAX = 2^B_WIDTH-1.
REQ-003 SHALL have parameter B_CLK, default 4, prescaler select width; prescaler counter width P = 2^B_CLK-1 bits.
REQ-004 SHALL have parameter PWM_POL, default 1, idle (inactive) output level; active level = ~PWM_POL.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port s_rst  input  1  synchronous soft restart of the period.
REQ-008 SHALL have port count_en  input  1  global count enable.
REQ-009 SHALL have port sel_clk  input  B_CLK  prescale select; tick every 2^sel_clk enabled clocks.
REQ-010 SHALL have port mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-011 SHALL have port duty  input  N_CH*B_WIDTH  packed duty per channel, channel i at bits [i*B_WIDTH +: B_WIDTH].
REQ-012 SHALL have port ch_en  input  N_CH  per-channel output enable.
REQ-013 SHALL have port pwm  output  N_CH  registered PWM outputs.
REQ-014 SHALL have port clk_en  output  1  one-clock tick strobe for pipelined consumers.
REQ-015 SHALL have port cyc  output  1  one-clock period-start strobe.

Function
REQ-016 Prescaler pre_cnt (P bits) SHALL increment by 1 each clk with count_en=1, wrapping at 2^P-1 to 0; hold when count_en=0.
REQ-017 clk_en SHALL be combinational: count_en & ((pre_cnt & m) == m), m = (1<<sel_clk)-1; sel_clk=0 gives clk_en=count_en.
REQ-018 Period counter cnt (B_WIDTH bits) and direction flag dir SHALL update only on clk_en=1.
REQ-019 Edge mode: cnt SHALL count 0,1..MAX, then wrap to 0; period = MAX+1 ticks.
REQ-020 Center mode: cnt SHALL count up 0..MAX with dir=up, then down MAX-1..1 with dir=down, then 0; period = 2*MAX ticks.
REQ-021 cyc SHALL equal clk_en & (cnt == 0).
REQ-022 On cyc=1, shadow registers duty_sh[i] and mode_sh SHALL load from duty and mode; duty/mode changes at other times SHALL NOT affect the current period.
REQ-023 On clk_en=1, pwm[i] SHALL register PWM_POL ^ (ch_en[i] & (cnt < duty_sh[i])), using the pre-update cnt (one-clock latency from tick).
REQ-024 pwm[i] SHALL hold its value between clk_en strobes.
REQ-025 duty_sh[i]=0 SHALL give constant idle level; edge mode duty_sh[i]=d SHALL give d active ticks of MAX+1; center mode d>=1 SHALL give 2d-1 active ticks of 2*MAX, symmetric about cnt=0.
REQ-026 ch_en[i]=0 SHALL force pwm[i] to idle at the next clk_en; ch_en is not shadowed.
REQ-027 Mode switch SHALL take effect only at cyc; on switch to edge, dir SHALL be cleared to up.
REQ-028 s_rst=1 SHALL, on the next clk regardless of count_en, clear pre_cnt, cnt and dir to 0/up, drive pwm to all PWM_POL, and load duty_sh/mode_sh from inputs; clk_en and cyc SHALL be 0 while s_rst=1.
REQ-029 Priority SHALL be rst_n > s_rst > count_en.

Reset
REQ-030 On rising clk with rst_n=0: pre_cnt=0, cnt=0, dir=up, duty_sh=0, mode_sh=0, pwm={N_CH{PWM_POL}}; clk_en and cyc SHALL be 0 while rst_n=0.
REQ-031 First cyc after rst_n release SHALL occur on the first clk_en.

Verification (N_CH=2, B_WIDTH=4, B_CLK=2, PWM_POL=1)
REQ-032 count_en=1, sel_clk=0, mode=0, duty ch0=4, ch_en=11 -> pwm[0] low 4 clks / high 12 clks, period 16, cyc every 16 clks.
REQ-033 sel_clk=2 -> clk_en every 4th clk; duty ch1=8 -> pwm[1] low 32 clks of 64.
REQ-034 duty ch0 4->10 at cnt=7 -> current period keeps 4 low ticks, next period 10 low ticks.
REQ-035 mode=1, duty ch0=3 -> period 30 ticks, pwm[0] low 5 ticks centred on cnt=0.
REQ-036 s_rst pulse at cnt=9 -> next clk pwm=11, cnt=0; counting resumes after s_rst falls.
REQ-037 duty=0 or ch_en[i]=0 -> pwm[i] stays 1; rst_n=0 mid-period -> pwm=11, cnt=0 next clk.

Source files
------------

// File: rtl/pwm_mc.sv
// pwm_mc: multi-channel PWM generator with a shared prescaler and period
// counter. Edge-aligned or center-aligned counting, per-channel duty and
// mode shadowed at each period start, soft restart and per-channel enable.
// clk_en and cyc are combinational strobes derived from the current state
// so downstream pipelined logic can align to the same clock as the tick.

module pwm_mc #(
  parameter int N_CH    = 4,
  parameter int B_WIDTH = 8,
  parameter int B_CLK   = 4,
  parameter bit PWM_POL = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_rst,
  input  logic                      count_en,
  input  logic [B_CLK-1:0]          sel_clk,
  input  logic                      mode,
  input  logic [N_CH*B_WIDTH-1:0]   duty,
  input  logic [N_CH-1:0]           ch_en,
  output logic [N_CH-1:0]           pwm,
  output logic                      clk_en,
  output logic                      cyc
);

  // Prescaler width: wide enough that every sel_clk value has a full mask.
  localparam int P = (1 << B_CLK) - 1;

  localparam logic [B_WIDTH-1:0] CNT_ZERO = {B_WIDTH{1'b0}};
  localparam logic [B_WIDTH-1:0] CNT_ONE  = B_WIDTH'(1);
  localparam logic [B_WIDTH-1:0] CNT_MAX  = {B_WIDTH{1'b1}};
  localparam logic [P-1:0]       PRE_ZERO = {P{1'b0}};
  localparam logic [P-1:0]       PRE_ONE  = P'(1);
  localparam logic [N_CH-1:0]    PWM_IDLE = {N_CH{PWM_POL}};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  // State registers and their next-state values.
  logic [P-1:0]              pre_cnt_q, pre_cnt_d;
  logic [B_WIDTH-1:0]        cnt_q,     cnt_d;
  dir_e                      dir_q,     dir_d;
  mode_e                     mode_sh_q, mode_sh_d;
  logic [N_CH*B_WIDTH-1:0]   duty_sh_q, duty_sh_d;
  logic [N_CH-1:0]           pwm_q,     pwm_d;

  // Combinational helpers.
  logic [P-1:0]              mask_s;
  logic                      tick_s;
  logic                      cyc_s;
  mode_e                     mode_eff_s;
  logic [N_CH*B_WIDTH-1:0]   duty_eff_s;
  logic [B_WIDTH-1:0]        ch_duty_s;

  // Build the prescaler mask: the low sel_clk bits set, the rest clear.
  always_comb begin
    mask_s = PRE_ZERO;
    for (int k = 0; k < P; k++) begin
      mask_s[k] = (sel_clk > B_CLK'(k));
    end
  end

  // A tick fires when all masked prescaler bits are set; reset and soft
  // restart both suppress it so nothing advances while they are asserted.
  assign tick_s = rst_n & ~s_rst & count_en & ((pre_cnt_q & mask_s) == mask_s);
  assign cyc_s  = tick_s & (cnt_q == CNT_ZERO);

  assign clk_en = tick_s;
  assign cyc    = cyc_s;
  assign pwm    = pwm_q;

  // Prescaler next state: free-running while enabled, cleared by soft restart.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (s_rst) begin
      pre_cnt_d = PRE_ZERO;
    end else if (count_en) begin
      pre_cnt_d = pre_cnt_q + PRE_ONE;
    end else begin
      pre_cnt_d = pre_cnt_q;
    end
  end

  // Shadow registers: capture duty and mode at period start; the values
  // used on the period-start tick itself are the freshly captured ones so a
  // new period is never shortened by one tick of stale duty.
  always_comb begin
    duty_sh_d  = duty_sh_q;
    mode_sh_d  = mode_sh_q;
    duty_eff_s = duty_sh_q;
    mode_eff_s = mode_sh_q;
    if (s_rst) begin
      duty_sh_d = duty;
      mode_sh_d = mode_e'(mode);
    end else if (cyc_s) begin
      duty_sh_d  = duty;
      mode_sh_d  = mode_e'(mode);
      duty_eff_s = duty;
      mode_eff_s = mode_e'(mode);
    end else begin
      duty_sh_d  = duty_sh_q;
      mode_sh_d  = mode_sh_q;
    end
  end

  // Period counter and direction: edge mode ramps up and wraps, center mode
  // ramps up to MAX then down to 1 before returning to 0.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (s_rst) begin
      cnt_d = CNT_ZERO;
      dir_d = DIR_UP;
    end else if (tick_s) begin
      case (mode_eff_s)
        MODE_EDGE: begin
          cnt_d = cnt_q + CNT_ONE;
          dir_d = DIR_UP;
        end
        MODE_CENTER: begin
          case (dir_q)
            DIR_UP: begin
              if (cnt_q == CNT_MAX) begin
                cnt_d = CNT_MAX - CNT_ONE;
                dir_d = DIR_DOWN;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
                dir_d = DIR_UP;
              end
            end
            DIR_DOWN: begin
              // Guard against 0 so a down count can never underflow to MAX.
              if (cnt_q <= CNT_ONE) begin
                cnt_d = CNT_ZERO;
                dir_d = DIR_UP;
              end else begin
                cnt_d = cnt_q - CNT_ONE;
                dir_d = DIR_DOWN;
              end
            end
            default: begin
              cnt_d = CNT_ZERO;
              dir_d = DIR_UP;
            end
          endcase
        end
        default: begin
          cnt_d = CNT_ZERO;
          dir_d = DIR_UP;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
      dir_d = dir_q;
    end
  end

  // PWM compare: on each tick, a channel is active while the pre-update
  // count is below its duty; disabled channels fall to idle.
  always_comb begin
    pwm_d     = pwm_q;
    ch_duty_s = CNT_ZERO;
    if (s_rst) begin
      pwm_d = PWM_IDLE;
    end else if (tick_s) begin
      for (int i = 0; i < N_CH; i++) begin
        ch_duty_s = duty_eff_s[i*B_WIDTH +: B_WIDTH];
        pwm_d[i]  = PWM_POL ^ (ch_en[i] & (cnt_q < ch_duty_s));
      end
    end else begin
      pwm_d = pwm_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q <= PRE_ZERO;
      cnt_q     <= CNT_ZERO;
      dir_q     <= DIR_UP;
      mode_sh_q <= MODE_EDGE;
      duty_sh_q <= {(N_CH*B_WIDTH){1'b0}};
      pwm_q     <= PWM_IDLE;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      mode_sh_q <= mode_sh_d;
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_mc.sv
// Directed testbench for pwm_mc with N_CH=2, B_WIDTH=4, B_CLK=2, PWM_POL=1.
// Inputs change #1 after a rising edge; outputs are sampled at that point.

module tb_pwm_mc;

  logic       clk;
  logic       rst_n;
  logic       s_rst;
  logic       count_en;
  logic [1:0] sel_clk;
  logic       mode;
  logic [7:0] duty;
  logic [1:0] ch_en;
  logic [1:0] pwm;
  logic       clk_en;
  logic       cyc;

  int checks = 0;
  int errors = 0;

  pwm_mc #(
    .N_CH    (2),
    .B_WIDTH (4),
    .B_CLK   (2),
    .PWM_POL (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_rst    (s_rst),
    .count_en (count_en),
    .sel_clk  (sel_clk),
    .mode     (mode),
    .duty     (duty),
    .ch_en    (ch_en),
    .pwm      (pwm),
    .clk_en   (clk_en),
    .cyc      (cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance n clocks, tallying low samples per channel plus strobes.
  task automatic run_cnt(input int n, output int low0, output int low1,
                         output int ncyc, output int nen);
    low0 = 0; low1 = 0; ncyc = 0; nen = 0;
    for (int k = 0; k < n; k++) begin
      step(1);
      if (pwm[0] === 1'b0) low0++;
      if (pwm[1] === 1'b0) low1++;
      if (cyc === 1'b1)    ncyc++;
      if (clk_en === 1'b1) nen++;
    end
  endtask

  // Center-mode count value for tick index j (MAX=15, period 30).
  function automatic int center_cnt(input int j);
    int c;
    c = j % 30;
    return (c <= 15) ? c : 30 - c;
  endfunction

  initial begin
    int l0, l1, nc, ne, a0, a1, acyc, aen, mism, lows;
    rst_n = 1'b0; s_rst = 1'b0; count_en = 1'b1; sel_clk = 2'd0;
    mode = 1'b0; duty = {4'd0, 4'd4}; ch_en = 2'b11;

    // Reset state
    step(2);
    chk("reset_pwm", 32'(pwm), 32'd3);
    chk("reset_clk_en", 32'(clk_en), 32'd0);
    chk("reset_cyc", 32'(cyc), 32'd0);

    // First tick after release is a period start
    rst_n = 1'b1;
    #1;
    chk("first_cyc", 32'(cyc), 32'd1);

    // Edge mode, sel_clk=0, duty ch0=4: two periods of 16 clocks
    run_cnt(16, l0, l1, nc, ne);
    chk("edge_p1_low0", 32'(l0), 32'd4);
    chk("edge_p1_low1_duty0", 32'(l1), 32'd0);
    chk("edge_p1_cyc", 32'(nc), 32'd1);
    chk("edge_p1_clk_en", 32'(ne), 32'd16);
    run_cnt(16, l0, l1, nc, ne);
    chk("edge_p2_low0", 32'(l0), 32'd4);
    chk("edge_p2_cyc", 32'(nc), 32'd1);

    // Prescale by 4, duty ch1=8: 64-clock period
    sel_clk = 2'd2;
    duty = {4'd8, 4'd4};
    run_cnt(64, l0, l1, nc, ne);
    chk("pre4_low1", 32'(l1), 32'd32);
    chk("pre4_low0", 32'(l0), 32'd16);
    chk("pre4_clk_en", 32'(ne), 32'd16);
    chk("pre4_cyc", 32'(nc), 32'd1);
    chk("pre4_cnt_wrap", 32'(dut.cnt_q), 32'd0);

    // Duty ch0 changes 4->10 at cnt=7: current period unaffected
    sel_clk = 2'd0;
    run_cnt(7, a0, a1, acyc, aen);
    chk("shadow_cnt7", 32'(dut.cnt_q), 32'd7);
    duty = {4'd8, 4'd10};
    run_cnt(9, l0, l1, nc, ne);
    chk("shadow_cur_low0", 32'(a0 + l0), 32'd4);
    run_cnt(16, l0, l1, nc, ne);
    chk("shadow_next_low0", 32'(l0), 32'd10);

    // Center mode, duty ch0=3: 30-tick period, 5 low ticks centred on 0
    mode = 1'b1;
    duty = {4'd8, 4'd3};
    mism = 0; lows = 0; acyc = 0;
    for (int k = 1; k <= 60; k++) begin
      step(1);
      if (pwm[0] !== ((center_cnt(k - 1) < 3) ? 1'b0 : 1'b1)) mism++;
      if (pwm[0] === 1'b0) lows++;
      if (cyc === 1'b1) acyc++;
    end
    chk("center_shape_mismatches", 32'(mism), 32'd0);
    chk("center_low0", 32'(lows), 32'd10);
    chk("center_cyc", 32'(acyc), 32'd2);

    // Soft restart at cnt=9 (also switches back to edge mode)
    step(9);
    chk("srst_pre_cnt9", 32'(dut.cnt_q), 32'd9);
    s_rst = 1'b1;
    mode  = 1'b0;
    #1;
    chk("srst_clk_en", 32'(clk_en), 32'd0);
    chk("srst_cyc", 32'(cyc), 32'd0);
    step(1);
    chk("srst_pwm", 32'(pwm), 32'd3);
    chk("srst_cnt", 32'(dut.cnt_q), 32'd0);
    s_rst = 1'b0;
    #1;
    chk("srst_resume_cyc", 32'(cyc), 32'd1);
    step(3);
    chk("srst_resume_cnt", 32'(dut.cnt_q), 32'd3);

    // Channel 0 disabled: stays idle; channel 1 keeps duty 8
    step(13);
    ch_en = 2'b10;
    run_cnt(16, l0, l1, nc, ne);
    chk("chen0_low0", 32'(l0), 32'd0);
    chk("chen0_low1", 32'(l1), 32'd8);

    // Hard reset mid-period
    step(5);
    chk("mid_pwm1_active", 32'(pwm[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clk_en", 32'(clk_en), 32'd0);
    step(1);
    chk("rst_mid_pwm", 32'(pwm), 32'd3);
    chk("rst_mid_cnt", 32'(dut.cnt_q), 32'd0);

    // Count disabled after release: everything holds
    count_en = 1'b0;
    rst_n = 1'b1;
    step(4);
    chk("hold_cnt", 32'(dut.cnt_q), 32'd0);
    chk("hold_pre", 32'(dut.pre_cnt_q), 32'd0);
    chk("hold_clk_en", 32'(clk_en), 32'd0);
    chk("hold_pwm", 32'(pwm), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
